// File: rtl/multi_filter_processing_element.sv
// 1-D convolution PE: loads NUM_FILTERS filters and one IFMap, streams one psum per (window, filter).
// Define PSUM_SAT_EN for saturating psum arithmetic; the default build wraps modulo 2^PSUM_WIDTH.
module multi_filter_processing_element #(
    parameter int DATA_WIDTH      = 16,
    parameter int PSUM_WIDTH      = 32,
    parameter int IFMAP_DEPTH     = 32,
    parameter int MAX_FILTER_SIZE = 8,
    parameter int NUM_FILTERS     = 4,
    parameter int STRIDE_WIDTH    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [STRIDE_WIDTH-1:0]            stride_in,
    input  logic [$clog2(MAX_FILTER_SIZE):0]   filter_size_in,
    input  logic [$clog2(IFMAP_DEPTH):0]       ifmap_size_in,
    input  logic [$clog2(NUM_FILTERS):0]       num_filters_in,
    output logic                               ready,
    output logic                               done,
    output logic                               cfg_err,
    input  logic [DATA_WIDTH-1:0]              filter_data,
    input  logic                               filter_valid,
    output logic                               filter_ren,
    input  logic [DATA_WIDTH-1:0]              ifmap_data,
    input  logic                               ifmap_valid,
    output logic                               ifmap_ren,
    input  logic [PSUM_WIDTH-1:0]              psum_in_data,
    input  logic                               psum_in_valid,
    output logic                               psum_in_ren,
    output logic [PSUM_WIDTH-1:0]              psum_out_data,
    output logic                               psum_out_valid,
    input  logic                               psum_out_ready
);
    // state  | meaning
    // IDLE   | waiting for start, config checked here
    // LD_FLT | loading num_filters*filter_size filter words, filter-major
    // LD_IF  | loading ifmap_size IFMap words
    // MAC    | one tap per cycle for the current (window, filter)
    // ACC_IN | waiting for the upstream psum, adds it to the accumulator
    // OUT    | holding psum_out until accepted downstream
    // DONE   | one-cycle done pulse
    localparam int FS_W = $clog2(MAX_FILTER_SIZE) + 1;
    localparam int IS_W = $clog2(IFMAP_DEPTH) + 1;
    localparam int NF_W = $clog2(NUM_FILTERS) + 1;
    localparam int IA_W = $clog2(IFMAP_DEPTH);
    localparam int FA_W = $clog2(NUM_FILTERS * MAX_FILTER_SIZE);
    localparam int AW   = IS_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_FLT, S_LD_IF, S_MAC, S_ACC_IN, S_OUT, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [DATA_WIDTH-1:0]   r_filter [NUM_FILTERS*MAX_FILTER_SIZE];
    logic [DATA_WIDTH-1:0]   r_ifmap  [IFMAP_DEPTH];

    logic [STRIDE_WIDTH-1:0] r_stride;
    logic [FS_W-1:0]         r_fs, r_k;
    logic [IS_W-1:0]         r_is, r_ld_addr, r_win_base;
    logic [NF_W-1:0]         r_nf, r_f;
    logic [PSUM_WIDTH-1:0]   r_acc, r_psum_out;
    logic                    r_psum_valid, r_cfg_err;

    logic                          w_legal, w_flt_xfer, w_if_xfer, w_pin_xfer;
    logic                          w_k_last, w_f_last, w_win_last, w_ld_if_last;
    logic [FA_W-1:0]               w_flt_addr;
    logic [IA_W-1:0]               w_if_addr;
    logic signed [DATA_WIDTH-1:0]  w_if_word, w_flt_word;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [PSUM_WIDTH-1:0]         w_prod_ext, w_acc_base, w_mac_next, w_psum_next;

    assign w_legal = (stride_in != '0)
                  && (filter_size_in != '0)
                  && (filter_size_in <= FS_W'(MAX_FILTER_SIZE))
                  && (IS_W'(filter_size_in) <= ifmap_size_in)
                  && (ifmap_size_in <= IS_W'(IFMAP_DEPTH))
                  && (num_filters_in != '0)
                  && (num_filters_in <= NF_W'(NUM_FILTERS));

    assign w_flt_xfer   = (r_state == S_LD_FLT) && filter_valid;
    assign w_if_xfer    = (r_state == S_LD_IF)  && ifmap_valid;
    assign w_pin_xfer   = (r_state == S_ACC_IN) && psum_in_valid;
    assign w_k_last     = (r_k == r_fs - FS_W'(1));
    assign w_f_last     = (r_f == r_nf - NF_W'(1));
    assign w_ld_if_last = (r_ld_addr == r_is - IS_W'(1));
    // The current window is the last one when the next window would run past the IFMap end.
    assign w_win_last   = (AW'(r_win_base) + AW'(r_stride) + AW'(r_fs)) > AW'(r_is);

    assign w_flt_addr = FA_W'(r_f) * FA_W'(MAX_FILTER_SIZE) + FA_W'(r_k);
    assign w_if_addr  = IA_W'(r_win_base) + IA_W'(r_k);
    assign w_if_word  = r_ifmap[w_if_addr];
    assign w_flt_word = r_filter[w_flt_addr];
    assign w_prod     = w_if_word * w_flt_word;
    assign w_prod_ext = PSUM_WIDTH'(w_prod);
    assign w_acc_base = (r_k == '0) ? '0 : r_acc;

`ifdef PSUM_SAT_EN
    logic                  r_sat;
    logic                  w_mac_keep, w_mac_ovf, w_psum_ovf;
    logic [PSUM_WIDTH:0]   w_mac_wide, w_psum_wide;

    function automatic logic [PSUM_WIDTH-1:0] f_clamp(input logic neg);
        return neg ? {1'b1, {(PSUM_WIDTH-1){1'b0}}} : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    endfunction

    // Once a (window, filter) result hits a rail it stays there until the next one starts.
    assign w_mac_keep  = (r_k != '0) && r_sat;
    assign w_mac_wide  = {w_acc_base[PSUM_WIDTH-1], w_acc_base} + {w_prod_ext[PSUM_WIDTH-1], w_prod_ext};
    assign w_mac_ovf   = w_mac_wide[PSUM_WIDTH] != w_mac_wide[PSUM_WIDTH-1];
    assign w_mac_next  = w_mac_keep ? r_acc :
                         w_mac_ovf  ? f_clamp(w_mac_wide[PSUM_WIDTH]) : w_mac_wide[PSUM_WIDTH-1:0];
    assign w_psum_wide = {r_acc[PSUM_WIDTH-1], r_acc} + {psum_in_data[PSUM_WIDTH-1], psum_in_data};
    assign w_psum_ovf  = w_psum_wide[PSUM_WIDTH] != w_psum_wide[PSUM_WIDTH-1];
    assign w_psum_next = r_sat      ? r_acc :
                         w_psum_ovf ? f_clamp(w_psum_wide[PSUM_WIDTH]) : w_psum_wide[PSUM_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (r_state == S_MAC) begin
            r_sat <= w_mac_keep | w_mac_ovf;
        end
    end
`else
    assign w_mac_next  = w_acc_base + w_prod_ext;
    assign w_psum_next = r_acc + psum_in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start && w_legal) w_state_nxt = S_LD_FLT;
            S_LD_FLT: if (w_flt_xfer && w_k_last && w_f_last) w_state_nxt = S_LD_IF;
            S_LD_IF:  if (w_if_xfer && w_ld_if_last) w_state_nxt = S_MAC;
            S_MAC:    if (w_k_last) w_state_nxt = S_ACC_IN;
            S_ACC_IN: if (psum_in_valid) w_state_nxt = S_OUT;
            S_OUT:    if (psum_out_ready) w_state_nxt = (w_f_last && w_win_last) ? S_DONE : S_MAC;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_flt_xfer) r_filter[w_flt_addr] <= filter_data;
        if (w_if_xfer)  r_ifmap[r_ld_addr[IA_W-1:0]] <= ifmap_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride     <= '0;
            r_fs         <= '0;
            r_is         <= '0;
            r_nf         <= '0;
            r_k          <= '0;
            r_f          <= '0;
            r_ld_addr    <= '0;
            r_win_base   <= '0;
            r_acc        <= '0;
            r_psum_out   <= '0;
            r_psum_valid <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && start && !w_legal;
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_stride   <= stride_in;
                        r_fs       <= filter_size_in;
                        r_is       <= ifmap_size_in;
                        r_nf       <= num_filters_in;
                        r_k        <= '0;
                        r_f        <= '0;
                        r_ld_addr  <= '0;
                        r_win_base <= '0;
                    end
                end
                S_LD_FLT: begin
                    if (w_flt_xfer) begin
                        if (w_k_last) begin
                            r_k <= '0;
                            r_f <= w_f_last ? '0 : r_f + NF_W'(1);
                        end else begin
                            r_k <= r_k + FS_W'(1);
                        end
                    end
                end
                S_LD_IF: begin
                    if (w_if_xfer) r_ld_addr <= r_ld_addr + IS_W'(1);
                end
                S_MAC: begin
                    r_acc <= w_mac_next;
                    r_k   <= w_k_last ? '0 : r_k + FS_W'(1);
                end
                S_ACC_IN: begin
                    if (w_pin_xfer) begin
                        r_psum_out   <= w_psum_next;
                        r_psum_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (psum_out_ready) begin
                        r_psum_valid <= 1'b0;
                        if (w_f_last) begin
                            r_f        <= '0;
                            r_win_base <= r_win_base + IS_W'(r_stride);
                        end else begin
                            r_f <= r_f + NF_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready          = (r_state == S_IDLE);
    assign done           = (r_state == S_DONE);
    assign cfg_err        = r_cfg_err;
    assign filter_ren     = (r_state == S_LD_FLT);
    assign ifmap_ren      = (r_state == S_LD_IF);
    assign psum_in_ren    = (r_state == S_ACC_IN);
    assign psum_out_data  = r_psum_out;
    assign psum_out_valid = r_psum_valid;

endmodule

// File: tb/tb_multi_filter_processing_element.sv
// Self-checking bench for multi_filter_processing_element: directed scenarios plus randomized passes
// compared against an arithmetic reference model (honours PSUM_SAT_EN when defined).
module tb_multi_filter_processing_element;
    localparam int DW   = 16;
    localparam int PW   = 32;
    localparam int ID   = 32;
    localparam int MF   = 8;
    localparam int NF   = 4;
    localparam int SW   = 3;
    localparam int FS_W = $clog2(MF) + 1;
    localparam int IS_W = $clog2(ID) + 1;
    localparam int NF_W = $clog2(NF) + 1;
    localparam longint HI = (longint'(1) <<< (PW-1)) - 1;
    localparam longint LO = -(longint'(1) <<< (PW-1));

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [SW-1:0]   stride_in = '0;
    logic [FS_W-1:0] filter_size_in = '0;
    logic [IS_W-1:0] ifmap_size_in = '0;
    logic [NF_W-1:0] num_filters_in = '0;
    logic            ready, done, cfg_err;
    logic [DW-1:0]   filter_data = '0;
    logic            filter_valid = 1'b0;
    logic            filter_ren;
    logic [DW-1:0]   ifmap_data = '0;
    logic            ifmap_valid = 1'b0;
    logic            ifmap_ren;
    logic [PW-1:0]   psum_in_data = '0;
    logic            psum_in_valid = 1'b0;
    logic            psum_in_ren;
    logic [PW-1:0]   psum_out_data;
    logic            psum_out_valid;
    logic            psum_out_ready = 1'b0;

    multi_filter_processing_element #(
        .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .IFMAP_DEPTH(ID),
        .MAX_FILTER_SIZE(MF), .NUM_FILTERS(NF), .STRIDE_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .stride_in(stride_in), .filter_size_in(filter_size_in),
        .ifmap_size_in(ifmap_size_in), .num_filters_in(num_filters_in),
        .ready(ready), .done(done), .cfg_err(cfg_err),
        .filter_data(filter_data), .filter_valid(filter_valid), .filter_ren(filter_ren),
        .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_ren(ifmap_ren),
        .psum_in_data(psum_in_data), .psum_in_valid(psum_in_valid), .psum_in_ren(psum_in_ren),
        .psum_out_data(psum_out_data), .psum_out_valid(psum_out_valid),
        .psum_out_ready(psum_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] flt_q[$];
    logic signed [DW-1:0] if_q[$];
    logic signed [PW-1:0] pin_q[$];
    logic [PW-1:0]        exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint wrapf(input longint v);
        logic signed [PW-1:0] t;
        t = v[PW-1:0];
        return longint'(t);
    endfunction

    function automatic void add_term(inout longint acc, inout bit clamped, input longint term);
`ifdef PSUM_SAT_EN
        if (!clamped) begin
            acc = acc + term;
            if (acc > HI) begin acc = HI; clamped = 1'b1; end
            else if (acc < LO) begin acc = LO; clamped = 1'b1; end
        end
`else
        acc = wrapf(acc + term);
        clamped = 1'b0;
`endif
    endfunction

    // Reference: every (window, filter) result from the queues, window-major, filter-minor.
    task automatic model(input int fs, input int is, input int st, input int nf);
        int nwin = (is - fs) / st + 1;
        int p = 0;
        exp_q.delete();
        for (int w = 0; w < nwin; w++) begin
            for (int f = 0; f < nf; f++) begin
                longint acc = 0;
                bit clamped = 1'b0;
                for (int k = 0; k < fs; k++)
                    add_term(acc, clamped, longint'(if_q[w*st+k]) * longint'(flt_q[f*fs+k]));
                add_term(acc, clamped, longint'(pin_q[p]));
                p++;
                exp_q.push_back(acc[PW-1:0]);
            end
        end
    endtask

    task automatic fill_random(input int fs, input int is, input int st, input int nf);
        int nwin = (is - fs) / st + 1;
        flt_q.delete(); if_q.delete(); pin_q.delete();
        for (int i = 0; i < nf*fs; i++) flt_q.push_back(DW'($urandom));
        for (int i = 0; i < is; i++) if_q.push_back(DW'($urandom));
        for (int i = 0; i < nwin*nf; i++) pin_q.push_back(PW'($urandom));
    endtask

    task automatic run_pass(input int fs, input int is, input int st, input int nf,
                            input bit stall_first, input int abort_after, input string tag);
        int fi = 0, ii = 0, pi = 0, oi = 0, cyc = 0, stall = 0;
        bit seen_done = 1'b0;
        bit acc_now;
        logic [PW-1:0] held = '0;
        @(negedge clk);
        stride_in = SW'(st); filter_size_in = FS_W'(fs);
        ifmap_size_in = IS_W'(is); num_filters_in = NF_W'(nf);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_ready"}, ready, 0);
        while (!seen_done && cyc < 20000) begin
            if (done) begin
                check({tag, "_psum_count"}, oi, exp_q.size());
                seen_done = 1'b1;
            end else begin
                acc_now = 1'b0;
                filter_valid  = ($urandom_range(0, 3) != 0);
                filter_data   = (fi < flt_q.size()) ? flt_q[fi] : '0;
                ifmap_valid   = ($urandom_range(0, 3) != 0);
                ifmap_data    = (ii < if_q.size()) ? if_q[ii] : '0;
                psum_in_valid = ($urandom_range(0, 2) != 0);
                psum_in_data  = (pi < pin_q.size()) ? pin_q[pi] : '0;
                if (psum_out_valid && stall_first && oi == 0 && stall < 5) begin
                    psum_out_ready = 1'b0;
                    if (stall == 0) held = psum_out_data;
                    else check({tag, "_stall_data"}, psum_out_data, held);
                    check({tag, "_stall_pin_ren"}, psum_in_ren, 0);
                    stall++;
                end else begin
                    psum_out_ready = ($urandom_range(0, 2) != 0);
                end
                if (filter_ren && filter_valid) fi++;
                if (ifmap_ren && ifmap_valid) ii++;
                if (psum_in_ren && psum_in_valid) pi++;
                if (psum_out_valid && psum_out_ready) begin
                    if (oi < exp_q.size()) check({tag, "_psum"}, psum_out_data, exp_q[oi]);
                    else check({tag, "_extra_psum"}, oi, exp_q.size());
                    if (stall_first && oi == 0) check({tag, "_stall_len"}, stall, 5);
                    oi++;
                    acc_now = 1'b1;
                end
                @(posedge clk);
                if (abort_after != 0 && acc_now && oi == abort_after) begin
                    @(negedge clk);
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    check({tag, "_rst_ready"}, ready, 1);
                    check({tag, "_rst_done"}, done, 0);
                    check({tag, "_rst_valid"}, psum_out_valid, 0);
                    check({tag, "_rst_data"}, psum_out_data, 0);
                    check({tag, "_rst_rens"}, {filter_ren, ifmap_ren, psum_in_ren}, 0);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_seen"}, seen_done, 1);
        @(negedge clk);
        check({tag, "_idle_ready"}, ready, 1);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic illegal(input int fs, input int is, input int st, input int nf, input string tag);
        @(negedge clk);
        stride_in = SW'(st); filter_size_in = FS_W'(fs);
        ifmap_size_in = IS_W'(is); num_filters_in = NF_W'(nf);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_cfg_err"}, cfg_err, 1);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_rens"}, {filter_ren, ifmap_ren, psum_in_ren}, 0);
        @(negedge clk);
        check({tag, "_cfg_err_drop"}, cfg_err, 0);
        check({tag, "_ready2"}, ready, 1);
    endtask

    task automatic setup_s1();
        flt_q.delete(); if_q.delete(); pin_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) flt_q.push_back(16'sd1);
        for (int i = 1; i <= 8; i++) if_q.push_back(DW'(i));
        for (int i = 0; i < 6; i++) pin_q.push_back('0);
        for (int i = 0; i < 6; i++) exp_q.push_back(PW'(6 + 3*i));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_cfg_err", cfg_err, 0);
        check("reset_rens", {filter_ren, ifmap_ren, psum_in_ren}, 0);
        check("reset_valid", psum_out_valid, 0);
        check("reset_data", psum_out_data, 0);
        rst = 1'b0;

        setup_s1();
        run_pass(3, 8, 1, 1, 1'b0, 0, "s1");

        flt_q.delete(); if_q.delete(); pin_q.delete(); exp_q.delete();
        flt_q.push_back(16'sd1); flt_q.push_back(16'sd0); flt_q.push_back(-16'sd1);
        for (int i = 0; i < 3; i++) flt_q.push_back(16'sd2);
        for (int i = 1; i <= 5; i++) if_q.push_back(DW'(i));
        for (int i = 0; i < 4; i++) pin_q.push_back(PW'(10));
        exp_q.push_back(PW'(8)); exp_q.push_back(PW'(22));
        exp_q.push_back(PW'(8)); exp_q.push_back(PW'(34));
        run_pass(3, 5, 2, 2, 1'b0, 0, "s2");

        setup_s1();
        run_pass(3, 8, 1, 1, 1'b1, 0, "s3");

        illegal(0, 8, 1, 1, "s4_fs0");
        illegal(3, 2, 1, 1, "s4_is_lt_fs");
        illegal(3, 8, 1, NF + 1, "s4_nf_big");

        setup_s1();
        run_pass(3, 8, 1, 1, 1'b0, 1, "s5_abort");
        setup_s1();
        run_pass(3, 8, 1, 1, 1'b0, 0, "s5_rerun");

        flt_q.delete(); if_q.delete(); pin_q.delete();
        for (int i = 0; i < 8; i++) begin
            flt_q.push_back(16'sh7FFF);
            if_q.push_back(16'sh7FFF);
        end
        pin_q.push_back(32'sh7FFFFFFF);
        model(8, 8, 1, 1);
        run_pass(8, 8, 1, 1, 1'b0, 0, "s6_big");

        for (int r = 0; r < 4; r++) begin
            int fs = $urandom_range(1, MF);
            int is = $urandom_range(fs, ID);
            int st = $urandom_range(1, 7);
            int nf = $urandom_range(1, NF);
            fill_random(fs, is, st, nf);
            model(fs, is, st, nf);
            run_pass(fs, is, st, nf, 1'b0, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
